// File: rtl/cpu_instr_sequencer.sv
// cpu_instr_sequencer: FIFO-buffered load/start/wait driver for the cpu instruction interface
module cpu_instr_sequencer #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [15:0]      wr_data,
    output logic             full,
    output logic             empty,
    input  logic             run,
    input  logic             cpu_w,
    input  logic [15:0]      cpu_out,
    input  logic             cpu_N,
    input  logic             cpu_V,
    input  logic             cpu_Z,
    output logic [15:0]      cpu_in,
    output logic             cpu_load,
    output logic             cpu_s,
    output logic [15:0]      result,
    output logic [2:0]       flags,
    output logic             result_valid,
    output logic [CNT_W-1:0] issued_count,
    output logic             busy,
    output logic             error
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, LOAD, START, EXEC, ERR} state_t;

    state_t           state_q, state_d;
    logic [15:0]      mem_q [DEPTH];
    logic [AW-1:0]    wp_q, rp_q;
    logic [AW:0]      cnt_q;
    logic [TW-1:0]    to_q, to_d;
    logic [15:0]      cpu_in_q, result_q;
    logic [2:0]       flags_q;
    logic             rv_q;
    logic [CNT_W-1:0] issued_q;
    logic             push, pop, issue;

    assign full         = cnt_q == (AW+1)'(DEPTH);
    assign empty        = cnt_q == '0;
    assign push         = wr_en && !full;
    assign pop          = state_q == EXEC && cpu_w;
    assign issue        = state_q == IDLE && run && !empty && cpu_w;
    assign cpu_in       = cpu_in_q;
    assign result       = result_q;
    assign flags        = flags_q;
    assign result_valid = rv_q;
    assign issued_count = issued_q;

    // FIFO storage has no reset; only pointers and count define its contents
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= wr_data;
    end

    // state register plus FIFO bookkeeping and captured results
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
            to_q     <= '0;
            cpu_in_q <= '0;
            result_q <= '0;
            flags_q  <= '0;
            rv_q     <= 1'b0;
            issued_q <= '0;
        end else begin
            state_q <= state_d;
            to_q    <= to_d;
            cnt_q   <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
            rv_q    <= pop;
            if (push) wp_q <= wp_q + 1'b1;
            if (pop) rp_q <= rp_q + 1'b1;
            if (issue) cpu_in_q <= mem_q[rp_q];
            if (pop) begin
                result_q <= cpu_out;
                flags_q  <= {cpu_N, cpu_V, cpu_Z};
                issued_q <= issued_q + 1'b1;
            end
        end
    end

    // next state and handshake timeout counter, which only runs while start is held with wait high
    always_comb begin
        state_d = state_q;
        to_d    = (state_q == START && cpu_w) ? to_q + 1'b1 : '0;
        case (state_q)
            IDLE:    state_d = issue ? LOAD : IDLE;
            LOAD:    state_d = START;
            START:   state_d = !cpu_w ? EXEC : (to_q == TW'(TIMEOUT - 1)) ? ERR : START;
            EXEC:    state_d = cpu_w ? IDLE : EXEC;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    // handshake outputs decoded straight from the registered state
    always_comb begin
        cpu_load = state_q == LOAD;
        cpu_s    = state_q == START;
        busy     = state_q != IDLE;
        error    = state_q == ERR;
    end
endmodule
